seq_mag_comp: RTL
=================

// Module: seq_mag_comp
// PURPOSE
//   Parametrised, multi-cycle magnitude comparator with signed/unsigned mode.
//   - Compares two WIDTH-bit operands CHUNK bits per cycle, MSB chunk first, with early exit on the first unequal chunk.
//   - Returns a one-hot {gt,eq,lt} result over valid/ready handshakes.
//   - Serves the NovaEdge32 branch/SLT datapath where a full-width single-cycle compare is off the critical path budget.
// PARAMETERS
//   WIDTH   32  operand width in bits; must be a multiple of CHUNK
//   CHUNK    8  bits compared per cycle; NCHUNK = WIDTH/CHUNK, 1..32
// PORTS
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous, active-low reset
//   in_valid   in   1      operands/mode valid
//   in_ready   out  1      block can accept operands (high only in IDLE)
//   a          in   WIDTH  operand A
//   b          in   WIDTH  operand B
//   is_signed  in   1      1: two's-complement compare; 0: unsigned
//   out_valid  out  1      result valid (high only in DONE)
//   out_ready  in   1      consumer accepts result
//   out        out  3      one-hot result: 100 = A>B, 010 = A==B, 001 = A<B
//   cycles     out  $clog2(NCHUNK+1)  chunks examined for this result, 1..NCHUNK
// BEHAVIOUR
//   - Reset (async assert, sync release) forces:
//     - state = IDLE; in_ready = 1 (combinational from state); out_valid = 0.
//     - out = 3'b010; cycles = 0; operand registers and chunk index = 0.
//   - FSM states: IDLE, BUSY, DONE.
//   - IDLE: on in_valid && in_ready, register a, b, is_signed; idx <= NCHUNK-1; go to BUSY.
//     Otherwise hold. Operand inputs are ignored outside this accept cycle.
//   - BUSY: compare chunk idx of A vs B via comp_chunk.
//     - On the MSB chunk (idx == NCHUNK-1) with is_signed = 1, invert the top bit of both chunks before the unsigned compare.
//     - If the chunk is unequal: out <= chunk result; cycles <= NCHUNK-idx; go to DONE.
//     - Else if idx == 0: out <= 3'b010; cycles <= NCHUNK; go to DONE.
//     - Else idx <= idx-1 and stay in BUSY.
//   - Latency: out_valid rises k clock edges after the accept edge, where k is the number of chunks examined.
//     - Minimum 1 (MSB chunk differs); maximum NCHUNK (operands equal or differ only in chunk 0).
//   - DONE: out and cycles are stable while out_valid = 1.
//     - On out_ready, go to IDLE. out and cycles hold their last value in IDLE until the next result is registered.
//   - Throughput: one compare per (k+2) cycles minimum. There is no accept in the same cycle as the result handoff, so in_ready = 0 in DONE.
//   - NCHUNK == 1 degenerates to a registered single-cycle compare with k = 1 always.
//   - Signed boundaries are mandatory:
//     - MIN_INT < -1 < 0 < MAX_INT.
//     - Unsigned treats 0x8000_0000 > 0x7FFF_FFFF.
//   - Reset asserted in BUSY or DONE aborts immediately to IDLE with reset values. No partial result is ever flagged valid.
//   - out is always exactly one-hot after reset; 000 and multi-hot codes are illegal.
// STRUCTURE
//   - comp_pkg (shared):
//     - localparams CMP_GT = 3'b100, CMP_EQ = 3'b010, CMP_LT = 3'b001.
//     - State encodings S_IDLE/S_BUSY/S_DONE.
//     - Reused by the branch unit and SLT logic.
//   - Sub-module comp_chunk:
//     - Combinational CHUNK-wide unsigned compare with a flip_msb input.
//     - Output is the 3-bit one-hot code; it generalises the single-bit compare cell.
//   - seq_mag_comp: FSM, operand/index registers and result registers. Chunk select is a variable part-select on idx.
// TESTING
//   1. Reset: assert rst_n = 0 mid-BUSY -> next sample shows in_ready = 1, out_valid = 0, out = 010, cycles = 0.
//   2. Unsigned, a = 32'h8000_0000, b = 32'h7FFF_FFFF -> out = 100, cycles = 1, out_valid rises 1 edge after accept.
//   3. Signed, a = 32'h8000_0000, b = 32'h7FFF_FFFF -> out = 001, cycles = 1; signed a = 32'hFFFF_FFFF, b = 0 -> out = 001.
//   4. Equal operands a = b = 32'h1234_5678 -> out = 010, cycles = 4, out_valid after 4 edges.
//   5. Differ only in LSB, a = 32'h0000_0001, b = 0 -> out = 100, cycles = 4; a = 32'h0001_0000, b = 0 -> cycles = 2.
//   6. Backpressure: hold out_ready = 0 for 5 cycles in DONE -> out/out_valid stable, in_ready = 0; release -> IDLE, next accept works.
//   Random signed/unsigned vs golden $signed/unsigned compare. Sweep CHUNK in {1, 8, 32}; assert one-hot out every cycle.

Source files
------------

// File: rtl/seq_mag_comp_pkg.sv
// Shared compare codes and FSM state encodings for the magnitude
// comparator, branch unit and SLT logic.
package comp_pkg;

  localparam logic [2:0] CMP_GT = 3'b100;
  localparam logic [2:0] CMP_EQ = 3'b010;
  localparam logic [2:0] CMP_LT = 3'b001;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_mag_comp_if.sv
// Operand request and result handshakes for the sequential
// magnitude comparator.
interface seq_mag_comp_if #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = $clog2(NCHUNK + 1);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             is_signed;
    logic             out_valid;
    logic             out_ready;
    logic [2:0]       out;
    logic [CW-1:0]    cycles;

    modport master (
        output in_valid, a, b, is_signed, out_ready,
        input  in_ready, out_valid, out, cycles
    );

    modport slave (
        input  in_valid, a, b, is_signed, out_ready,
        output in_ready, out_valid, out, cycles
    );

endinterface

// File: rtl/seq_mag_comp_chunk.sv
// One chunk of the magnitude compare: unsigned compare with an
// optional sign-bit flip that turns it into a two's-complement compare.
module comp_chunk
    import comp_pkg::*;
#(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a_i,
    input  logic [CHUNK-1:0] b_i,
    input  logic             flip_msb_i,
    output logic [2:0]       res_o
);

    logic [CHUNK-1:0] msk;
    logic [CHUNK-1:0] xa;
    logic [CHUNK-1:0] xb;

    always_comb begin
        msk            = '0;
        msk[CHUNK-1]   = flip_msb_i;
        xa             = a_i ^ msk;
        xb             = b_i ^ msk;
        res_o          = CMP_EQ;
        unique case (1'b1)
            (xa > xb): res_o = CMP_GT;
            (xa < xb): res_o = CMP_LT;
            default:   res_o = CMP_EQ;
        endcase
    end

endmodule

// File: rtl/seq_mag_comp.sv
// Multi-cycle magnitude comparator: walks operands MSB chunk first
// and stops at the first unequal chunk.
module seq_mag_comp
    import comp_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    seq_mag_comp_if.slave bus
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = $clog2(NCHUNK + 1);
    localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IW-1:0] IDX_TOP = IW'(NCHUNK - 1);

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             sgn_q;
    logic [IW-1:0]    idx_q;
    logic [2:0]       out_q;
    logic [CW-1:0]    cyc_q;

    logic [CHUNK-1:0] ca;
    logic [CHUNK-1:0] cb;
    logic             flip;
    logic [2:0]       cres;

    assign ca   = a_q[int'(idx_q)*CHUNK +: CHUNK];
    assign cb   = b_q[int'(idx_q)*CHUNK +: CHUNK];
    assign flip = sgn_q && (idx_q == IDX_TOP);

    comp_chunk #(.CHUNK(CHUNK)) u_chunk (
        .a_i        (ca),
        .b_i        (cb),
        .flip_msb_i (flip),
        .res_o      (cres)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sgn_q   <= 1'b0;
            idx_q   <= '0;
            out_q   <= CMP_EQ;
            cyc_q   <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        a_q     <= bus.a;
                        b_q     <= bus.b;
                        sgn_q   <= bus.is_signed;
                        idx_q   <= IDX_TOP;
                        state_q <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (cres != CMP_EQ) begin
                        out_q   <= cres;
                        cyc_q   <= CW'(NCHUNK) - CW'(idx_q);
                        state_q <= S_DONE;
                    end else if (idx_q == '0) begin
                        out_q   <= CMP_EQ;
                        cyc_q   <= CW'(NCHUNK);
                        state_q <= S_DONE;
                    end else begin
                        idx_q   <= idx_q - 1'b1;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.out       = out_q;
    assign bus.cycles    = cyc_q;

endmodule
